noc_input_port: RTL and testbench
=================================

Name: noc_input_port

Overview:
- Input stage of a mesh NoC router port.
- Holds one flit FIFO per virtual channel (VC) and a per-VC packet state machine (IDLE/VA/ACTIVE).
- Computes the XY route from each HEAD flit and issues VA/SA requests.
- Drives the selected VC's front flit to the crossbar, with vc_id rewritten to the allocated downstream VC.
- Types and constants (flit_t, port_t, VC_NUM, VC_SIZE, MESH_SIZE_X/Y) come from package noc_params.

Parameters:
- BUFFER_SIZE, 8, flit depth of each VC FIFO (power of two, >=2).
- X_CURRENT, MESH_SIZE_X/2, x coordinate of this router.
- Y_CURRENT, MESH_SIZE_Y/2, y coordinate of this router.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_i  in  flit_t  incoming flit; vc_id selects the target FIFO.
- valid_flit_i  in  1  data_i valid this cycle.
- va_valid_i  in  VC_NUM  per-VC VC-allocation grant.
- va_new_vc_i  in  VC_NUM x VC_SIZE  downstream VC granted to each VC.
- sa_valid_i  in  1  switch-allocation grant: pop one flit this cycle.
- sa_sel_vc_i  in  VC_SIZE  VC granted by SA.
- xb_flit_o  out  flit_t  front flit of VC sa_sel_vc_i, vc_id replaced by that VC's downstream VC.
- is_on_off_o  out  VC_NUM  on/off credit to upstream (1 = may send).
- is_allocatable_vc_o  out  VC_NUM  VC is IDLE and empty.
- va_request_o  out  VC_NUM  VC in VA state.
- sa_request_o  out  VC_NUM x 1  VC in ACTIVE state and non-empty.
- sa_downstream_vc_o  out  VC_NUM x VC_SIZE  latched downstream VC per VC.
- out_port_o  out  VC_NUM x port_t  route of the packet held in each VC.
- is_full_o  out  VC_NUM  FIFO full.
- is_empty_o  out  VC_NUM  FIFO empty.
- err_o  out  VC_NUM  protocol/overflow error, pulsed for one cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - all FIFOs empty; all states IDLE.
  - sa_downstream_vc_o=0, out_port_o=LOCAL, err_o=0.
  - Resulting outputs: is_empty_o all 1, is_full_o 0, is_allocatable_vc_o all 1, is_on_off_o all 1.
  - Reset mid-packet discards all buffered flits.
- Write, on a rising edge with valid_flit_i=1 into FIFO[data_i.vc_id]. Acceptance depends on the VC's packet context:
  - HEAD/HEADTAIL, VC has no open packet: stored; packet opened. A HEADTAIL closes it immediately.
  - HEAD, packet already open: dropped; err_o pulses.
  - BODY/TAIL, packet open: stored. TAIL closes the packet.
  - BODY/TAIL, no open packet: dropped; FIFO stays empty; err_o pulses.
  - Write to a full FIFO: dropped, err_o pulses. Exception: if the same VC is popped in the same cycle, the write is accepted.
- Route, latched when a HEAD/HEADTAIL is stored:
  - x_dest>X_CURRENT gives EAST; x_dest<X_CURRENT gives WEST.
  - Otherwise y_dest>Y_CURRENT gives SOUTH; y_dest<Y_CURRENT gives NORTH.
  - Otherwise LOCAL.
- Per-VC FSM:
  - IDLE -> VA: when the FIFO front is HEAD/HEADTAIL (next cycle after the write).
  - VA: va_request_o=1. On va_valid_i[v], latch va_new_vc_i[v] into sa_downstream_vc_o[v] and go to ACTIVE. va_valid_i is ignored in other states.
  - ACTIVE: sa_request_o=1 while non-empty. Return to IDLE on the edge that pops a TAIL/HEADTAIL.
- Read:
  - xb_flit_o is combinational from FIFO[sa_sel_vc_i] front, with vc_id=sa_downstream_vc_o[sa_sel_vc_i]. Zero latency from grant.
  - On a rising edge with sa_valid_i=1, the selected FIFO pops if non-empty and ACTIVE. Otherwise no pop.
- FIFO is circular with wrap-around pointers. Packets longer than BUFFER_SIZE stream through under on/off control.
- is_on_off_o[v] = occupancy < BUFFER_SIZE-1 (one slot of slack for in-flight flit).

Optional Feature:
- Macro IP_ERR_DETECT_EN.
- Defined: err_o pulses as specified above.
- Undefined: err_o tied to 0. Illegal and overflow flits are still dropped silently.

Test Plan:
- VC v, HEAD+2 BODY+TAIL (4 flits) back-to-back, va_valid_i[v] at cycle 2 with new VC n, then sa_valid_i with sa_sel_vc_i=v every cycle -> 4 flits exit in order with vc_id=n; VC returns to IDLE; is_empty_o[v]=1.
- Same packet with 2 idle cycles between flits, SA one cycle after VA -> identical ordered output; sa_request_o drops while the FIFO is empty mid-packet.
- HEAD+TAIL only, then a 16-flit packet (BUFFER_SIZE=8) read one flit per cycle after VA -> all 16 in order; is_full_o never overflows; err_o=0.
- 6-flit packet with heads at positions 1-3 -> only the first HEAD is buffered; 4 flits delivered; err_o pulses twice (feature on).
- Single HEADTAIL -> VA then one SA pop; VC back to IDLE; is_allocatable_vc_o[v]=1.
- Two VCs interleaved (4 and 5 flits), different VA times, then BODY and TAIL with no HEAD -> each VC delivers its packet with its own downstream VC; the orphan flits leave is_empty_o[0]=1.

Source files
------------

// File: rtl/noc_input_port.sv
// NoC router input port: per-VC flit FIFOs, per-VC packet FSM, XY routing, VA/SA requests.
// Optional macro IP_ERR_DETECT_EN enables the one-cycle err_o pulse on dropped flits.

package noc_params;
    localparam int MESH_SIZE_X      = 4;
    localparam int MESH_SIZE_Y      = 4;
    localparam int VC_NUM           = 4;
    localparam int VC_SIZE          = $clog2(VC_NUM);
    localparam int DEST_ADDR_SIZE_X = $clog2(MESH_SIZE_X);
    localparam int DEST_ADDR_SIZE_Y = $clog2(MESH_SIZE_Y);
    localparam int PAYLOAD_SIZE     = 16;

    typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;
    typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

    typedef struct packed {
        flit_label_t                 flit_label;
        logic [VC_SIZE-1:0]          vc_id;
        logic [DEST_ADDR_SIZE_X-1:0] x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
        logic [PAYLOAD_SIZE-1:0]     data;
    } flit_t;
endpackage

module noc_input_port
    import noc_params::*;
#(
    parameter int BUFFER_SIZE = 8,
    parameter int X_CURRENT   = MESH_SIZE_X / 2,
    parameter int Y_CURRENT   = MESH_SIZE_Y / 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  flit_t                                  data_i,
    input  logic                                   valid_flit_i,
    input  logic [VC_NUM-1:0]                      va_valid_i,
    input  logic [VC_NUM-1:0][VC_SIZE-1:0]         va_new_vc_i,
    input  logic                                   sa_valid_i,
    input  logic [VC_SIZE-1:0]                     sa_sel_vc_i,
    output flit_t                                  xb_flit_o,
    output logic [VC_NUM-1:0]                      is_on_off_o,
    output logic [VC_NUM-1:0]                      is_allocatable_vc_o,
    output logic [VC_NUM-1:0]                      va_request_o,
    output logic [VC_NUM-1:0]                      sa_request_o,
    output logic [VC_NUM-1:0][VC_SIZE-1:0]         sa_downstream_vc_o,
    output port_t [VC_NUM-1:0]                     out_port_o,
    output logic [VC_NUM-1:0]                      is_full_o,
    output logic [VC_NUM-1:0]                      is_empty_o,
    output logic [VC_NUM-1:0]                      err_o
);
    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [DEST_ADDR_SIZE_X-1:0] X_CUR = DEST_ADDR_SIZE_X'(X_CURRENT);
    localparam logic [DEST_ADDR_SIZE_Y-1:0] Y_CUR = DEST_ADDR_SIZE_Y'(Y_CURRENT);

    typedef enum logic [1:0] {IDLE, VA, ACTIVE} vc_state_t;

    flit_t             mem [VC_NUM][BUFFER_SIZE];
    logic [PTR_W-1:0]  rd_ptr [VC_NUM];
    logic [PTR_W-1:0]  wr_ptr [VC_NUM];
    logic [CNT_W-1:0]  count [VC_NUM];
    logic [VC_NUM-1:0] pkt_open;
    vc_state_t         state [VC_NUM];
    vc_state_t         state_next [VC_NUM];
    logic [VC_NUM-1:0] push;
    logic [VC_NUM-1:0] pop;
    port_t             route;
    logic [VC_SIZE-1:0] wr_vc;
    logic              wr_head;

    assign wr_vc   = data_i.vc_id;
    assign wr_head = (data_i.flit_label == HEAD) || (data_i.flit_label == HEADTAIL);

    always_comb begin
        route = LOCAL;
        if (data_i.x_dest > X_CUR)      route = EAST;
        else if (data_i.x_dest < X_CUR) route = WEST;
        else if (data_i.y_dest > Y_CUR) route = SOUTH;
        else if (data_i.y_dest < Y_CUR) route = NORTH;
    end

    always_comb begin
        pop = '0;
        for (int unsigned v = 0; v < VC_NUM; v++)
            pop[v] = sa_valid_i && (sa_sel_vc_i == VC_SIZE'(v)) &&
                     (count[v] != '0) && (state[v] == ACTIVE);
    end

    // A head is legal only with no open packet, body/tail only with one: legal == (head != open).
    always_comb begin
        push = '0;
        if (valid_flit_i && (wr_head != pkt_open[wr_vc]) &&
            ((count[wr_vc] != CNT_W'(BUFFER_SIZE)) || pop[wr_vc]))
            push[wr_vc] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (|push) mem[wr_vc][wr_ptr[wr_vc]] <= data_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                rd_ptr[v]     <= '0;
                wr_ptr[v]     <= '0;
                count[v]      <= '0;
                out_port_o[v] <= LOCAL;
            end
            pkt_open <= '0;
        end else begin
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                if (push[v]) wr_ptr[v] <= wr_ptr[v] + PTR_W'(1);
                if (pop[v])  rd_ptr[v] <= rd_ptr[v] + PTR_W'(1);
                count[v] <= count[v] + CNT_W'(push[v]) - CNT_W'(pop[v]);
            end
            if (|push) begin
                case (data_i.flit_label)
                    HEAD:          pkt_open[wr_vc] <= 1'b1;
                    TAIL, HEADTAIL: pkt_open[wr_vc] <= 1'b0;
                    default: ;
                endcase
                if (wr_head) out_port_o[wr_vc] <= route;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned v = 0; v < VC_NUM; v++) state[v] <= IDLE;
            sa_downstream_vc_o <= '0;
        end else begin
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                state[v] <= state_next[v];
                if ((state[v] == VA) && va_valid_i[v]) sa_downstream_vc_o[v] <= va_new_vc_i[v];
            end
        end
    end

    always_comb begin
        va_request_o        = '0;
        sa_request_o        = '0;
        is_allocatable_vc_o = '0;
        for (int unsigned v = 0; v < VC_NUM; v++) begin
            state_next[v] = state[v];
            case (state[v])
                IDLE: begin
                    is_allocatable_vc_o[v] = (count[v] == '0);
                    if ((count[v] != '0) && ((mem[v][rd_ptr[v]].flit_label == HEAD) ||
                                             (mem[v][rd_ptr[v]].flit_label == HEADTAIL)))
                        state_next[v] = VA;
                end
                VA: begin
                    va_request_o[v] = 1'b1;
                    if (va_valid_i[v]) state_next[v] = ACTIVE;
                end
                ACTIVE: begin
                    sa_request_o[v] = (count[v] != '0);
                    if (pop[v] && ((mem[v][rd_ptr[v]].flit_label == TAIL) ||
                                   (mem[v][rd_ptr[v]].flit_label == HEADTAIL)))
                        state_next[v] = IDLE;
                end
                default: state_next[v] = IDLE;
            endcase
        end
    end

    always_comb begin
        for (int unsigned v = 0; v < VC_NUM; v++) begin
            is_empty_o[v]  = (count[v] == '0);
            is_full_o[v]   = (count[v] == CNT_W'(BUFFER_SIZE));
            is_on_off_o[v] = (count[v] < CNT_W'(BUFFER_SIZE - 1));
        end
    end

    always_comb begin
        xb_flit_o       = mem[sa_sel_vc_i][rd_ptr[sa_sel_vc_i]];
        xb_flit_o.vc_id = sa_downstream_vc_o[sa_sel_vc_i];
    end

`ifdef IP_ERR_DETECT_EN
    logic [VC_NUM-1:0] err_next;

    always_comb begin
        err_next = '0;
        if (valid_flit_i && !push[wr_vc]) err_next[wr_vc] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_o <= '0;
        else      err_o <= err_next;
    end
`else
    assign err_o = '0;
`endif

endmodule

// File: tb/tb_noc_input_port.sv
// Self-checking bench for noc_input_port: queue-based reference model plus a route vector table.
module tb_noc_input_port;
    import noc_params::*;

    localparam int B = 8;
`ifdef IP_ERR_DETECT_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic                           clk = 1'b0;
    logic                           rst;
    flit_t                          data_i;
    logic                           valid_flit_i;
    logic [VC_NUM-1:0]              va_valid_i;
    logic [VC_NUM-1:0][VC_SIZE-1:0] va_new_vc_i;
    logic                           sa_valid_i;
    logic [VC_SIZE-1:0]             sa_sel_vc_i;
    flit_t                          xb_flit_o;
    logic [VC_NUM-1:0]              is_on_off_o, is_allocatable_vc_o, va_request_o, sa_request_o;
    logic [VC_NUM-1:0][VC_SIZE-1:0] sa_downstream_vc_o;
    port_t [VC_NUM-1:0]             out_port_o;
    logic [VC_NUM-1:0]              is_full_o, is_empty_o, err_o;

    noc_input_port #(.BUFFER_SIZE(B)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_flit_i(valid_flit_i),
        .va_valid_i(va_valid_i), .va_new_vc_i(va_new_vc_i), .sa_valid_i(sa_valid_i),
        .sa_sel_vc_i(sa_sel_vc_i), .xb_flit_o(xb_flit_o), .is_on_off_o(is_on_off_o),
        .is_allocatable_vc_o(is_allocatable_vc_o), .va_request_o(va_request_o),
        .sa_request_o(sa_request_o), .sa_downstream_vc_o(sa_downstream_vc_o),
        .out_port_o(out_port_o), .is_full_o(is_full_o), .is_empty_o(is_empty_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // reference model state
    flit_t              q [VC_NUM][$];
    bit   [VC_NUM-1:0]  m_open;
    int                 m_st [VC_NUM];      // 0 idle, 1 va, 2 active
    logic [VC_SIZE-1:0] m_ds [VC_NUM];
    port_t              m_route [VC_NUM];
    logic [VC_NUM-1:0]  m_err;

    int checks = 0, passed = 0, err_seen = 0, tag = 0;
    flit_label_t lbl [0:31];

    typedef struct {
        logic [1:0] x;
        logic [1:0] y;
        port_t      exp_port;
    } route_vec_t;
    route_vec_t rtab [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic port_t xy(input logic [1:0] x, input logic [1:0] y);
        if (int'(x) > MESH_SIZE_X / 2) return EAST;
        if (int'(x) < MESH_SIZE_X / 2) return WEST;
        if (int'(y) > MESH_SIZE_Y / 2) return SOUTH;
        if (int'(y) < MESH_SIZE_Y / 2) return NORTH;
        return LOCAL;
    endfunction

    function automatic flit_t mk(input flit_label_t l, input int vc, input int idx,
                                 input logic [1:0] x, input logic [1:0] y);
        flit_t f;
        f.flit_label = l;
        f.vc_id      = VC_SIZE'(vc);
        f.x_dest     = x;
        f.y_dest     = y;
        f.data       = 16'(tag * 256 + vc * 32 + idx);
        return f;
    endfunction

    task automatic idle_inputs();
        valid_flit_i = 1'b0;
        va_valid_i   = '0;
        va_new_vc_i  = '0;
        sa_valid_i   = 1'b0;
        sa_sel_vc_i  = '0;
        data_i       = '0;
    endtask

    task automatic model_reset();
        for (int v = 0; v < VC_NUM; v++) begin
            q[v].delete();
            m_st[v]    = 0;
            m_ds[v]    = '0;
            m_route[v] = LOCAL;
        end
        m_open = '0;
        m_err  = '0;
    endtask

    task automatic compare();
        logic [VC_NUM-1:0] e_empty, e_full, e_onoff, e_va, e_sa, e_alloc;
        logic [VC_NUM-1:0][VC_SIZE-1:0] e_ds;
        port_t [VC_NUM-1:0] e_port;
        for (int v = 0; v < VC_NUM; v++) begin
            e_empty[v] = (q[v].size() == 0);
            e_full[v]  = (q[v].size() == B);
            e_onoff[v] = (q[v].size() < B - 1);
            e_va[v]    = (m_st[v] == 1);
            e_sa[v]    = (m_st[v] == 2) && (q[v].size() > 0);
            e_alloc[v] = (m_st[v] == 0) && (q[v].size() == 0);
            e_ds[v]    = m_ds[v];
            e_port[v]  = m_route[v];
            if (err_o[v] === 1'b1) err_seen++;
        end
        chk("is_empty", is_empty_o, e_empty);
        chk("is_full", is_full_o, e_full);
        chk("is_on_off", is_on_off_o, e_onoff);
        chk("va_request", va_request_o, e_va);
        chk("sa_request", sa_request_o, e_sa);
        chk("is_allocatable", is_allocatable_vc_o, e_alloc);
        chk("sa_downstream_vc", sa_downstream_vc_o, e_ds);
        chk("out_port", out_port_o, e_port);
        chk("err", err_o, m_err);
    endtask

    // Check crossbar output, advance the model across one rising edge, then compare all outputs.
    task automatic step();
        logic [VC_NUM-1:0] pop, nerr;
        bit acc, hd;
        int wv;
        flit_t exp;
        #1;
        pop  = '0;
        nerr = '0;
        for (int v = 0; v < VC_NUM; v++)
            pop[v] = sa_valid_i && (int'(sa_sel_vc_i) == v) && (q[v].size() > 0) && (m_st[v] == 2);
        if (pop[sa_sel_vc_i]) begin
            exp       = q[sa_sel_vc_i][0];
            exp.vc_id = m_ds[sa_sel_vc_i];
            chk("xb_flit", xb_flit_o, exp);
        end
        wv  = int'(data_i.vc_id);
        hd  = (data_i.flit_label == HEAD) || (data_i.flit_label == HEADTAIL);
        acc = valid_flit_i && (hd ? !m_open[wv] : m_open[wv]) && ((q[wv].size() < B) || pop[wv]);
        if (valid_flit_i && !acc) nerr[wv] = 1'b1;
        for (int v = 0; v < VC_NUM; v++) begin
            case (m_st[v])
                0: if (q[v].size() > 0 && (q[v][0].flit_label == HEAD || q[v][0].flit_label == HEADTAIL))
                       m_st[v] = 1;
                1: if (va_valid_i[v]) begin m_st[v] = 2; m_ds[v] = va_new_vc_i[v]; end
                default: if (pop[v] && (q[v][0].flit_label == TAIL || q[v][0].flit_label == HEADTAIL))
                       m_st[v] = 0;
            endcase
            if (pop[v]) void'(q[v].pop_front());
        end
        if (acc) begin
            q[wv].push_back(data_i);
            if (data_i.flit_label == HEAD) m_open[wv] = 1'b1;
            else if (data_i.flit_label != BODY) m_open[wv] = 1'b0;
            if (hd) m_route[wv] = xy(data_i.x_dest, data_i.y_dest);
        end
        m_err = ERR_ON ? nerr : '0;
        @(posedge clk);
        #1;
        compare();
    endtask

    // One VC: send lbl[0..n-1] with `gap` idle cycles between flits, VA grant at cycle va_at, SA from sa_from.
    task automatic stream(input int vc, input int n, input int gap, input int va_at, input int sa_from,
                          input int ds, input int cycles, input bit gate);
        int idx = 0, wait_c = 0;
        tag++;
        for (int c = 0; c < cycles; c++) begin
            idle_inputs();
            if (idx < n && wait_c == 0 && (!gate || q[vc].size() < B - 1)) begin
                data_i = mk(lbl[idx], vc, idx, 2'd3, 2'd1);
                valid_flit_i = 1'b1;
                idx++;
                wait_c = gap;
            end else if (wait_c > 0) wait_c--;
            if (c == va_at) begin va_valid_i[vc] = 1'b1; va_new_vc_i[vc] = VC_SIZE'(ds); end
            if (c >= sa_from) begin sa_valid_i = 1'b1; sa_sel_vc_i = VC_SIZE'(vc); end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rtab[0] = '{2'd3, 2'd2, EAST};
        rtab[1] = '{2'd0, 2'd3, WEST};
        rtab[2] = '{2'd2, 2'd3, SOUTH};
        rtab[3] = '{2'd2, 2'd0, NORTH};
        rtab[4] = '{2'd2, 2'd2, LOCAL};
        rtab[5] = '{2'd3, 2'd0, EAST};

        idle_inputs();
        model_reset();
        rst = 1'b0;
        #12;
        chk("rst_is_empty", is_empty_o, {VC_NUM{1'b1}});
        chk("rst_is_full", is_full_o, '0);
        chk("rst_is_allocatable", is_allocatable_vc_o, {VC_NUM{1'b1}});
        chk("rst_is_on_off", is_on_off_o, {VC_NUM{1'b1}});
        chk("rst_err", err_o, '0);
        chk("rst_sa_downstream_vc", sa_downstream_vc_o, '0);
        chk("rst_out_port", out_port_o, '0);
        chk("rst_va_request", va_request_o, '0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // back-to-back 4-flit packet
        lbl[0] = HEAD; lbl[1] = BODY; lbl[2] = BODY; lbl[3] = TAIL;
        stream(1, 4, 0, 2, 0, 2, 12, 1'b0);
        chk("t1_empty_vc1", is_empty_o[1], 1'b1);
        // same packet with 2-cycle gaps
        stream(1, 4, 2, 2, 3, 3, 16, 1'b0);
        // short packet then 16-flit packet streaming through an 8-deep FIFO
        lbl[0] = HEAD; lbl[1] = TAIL;
        stream(2, 2, 0, 2, 0, 1, 8, 1'b0);
        lbl[0] = HEAD;
        for (int i = 1; i < 15; i++) lbl[i] = BODY;
        lbl[15] = TAIL;
        err_seen = 0;
        stream(2, 16, 0, 2, 3, 0, 30, 1'b1);
        chk("t3_err_pulses", err_seen, 0);
        // extra heads in positions 2 and 3 are dropped
        lbl[0] = HEAD; lbl[1] = HEAD; lbl[2] = HEAD; lbl[3] = BODY; lbl[4] = BODY; lbl[5] = TAIL;
        err_seen = 0;
        stream(0, 6, 0, 2, 0, 3, 16, 1'b0);
        chk("t4_err_pulses", err_seen, ERR_ON ? 2 : 0);
        // single HEADTAIL
        lbl[0] = HEADTAIL;
        stream(3, 1, 0, 2, 0, 2, 6, 1'b0);
        chk("t5_allocatable_vc3", is_allocatable_vc_o[3], 1'b1);

        // two VCs interleaved, then orphan BODY/TAIL on VC0
        tag++;
        for (int c = 0; c < 40; c++) begin
            idle_inputs();
            if (c < 10 && c % 2 == 0 && c / 2 < 4) begin
                data_i = mk((c == 0) ? HEAD : (c == 6) ? TAIL : BODY, 0, c / 2, 2'd0, 2'd1);
                valid_flit_i = 1'b1;
            end else if (c < 10 && c % 2 == 1) begin
                data_i = mk((c == 1) ? HEAD : (c == 9) ? TAIL : BODY, 2, c / 2, 2'd2, 2'd3);
                valid_flit_i = 1'b1;
            end else if (c == 30 || c == 31) begin
                data_i = mk((c == 30) ? BODY : TAIL, 0, c, 2'd1, 2'd1);
                valid_flit_i = 1'b1;
            end
            if (c == 3) begin va_valid_i[0] = 1'b1; va_new_vc_i[0] = 2'd1; end
            if (c == 7) begin va_valid_i[2] = 1'b1; va_new_vc_i[2] = 2'd3; end
            if (c >= 10) begin sa_valid_i = 1'b1; sa_sel_vc_i = (c % 2 == 1) ? 2'd2 : 2'd0; end
            step();
        end
        idle_inputs();
        chk("t6_empty_vc0", is_empty_o[0], 1'b1);

        // fill VC1 to full, overflow write dropped, write accepted alongside a pop
        tag++;
        for (int c = 0; c < 24; c++) begin
            idle_inputs();
            if (c <= 9) begin
                data_i = mk((c == 0) ? HEAD : BODY, 1, c, 2'd3, 2'd3);
                valid_flit_i = 1'b1;
            end else if (c == 10) begin
                data_i = mk(TAIL, 1, c, 2'd3, 2'd3);
                valid_flit_i = 1'b1;
            end
            if (c == 2) begin va_valid_i[1] = 1'b1; va_new_vc_i[1] = 2'd1; end
            if (c >= 9) begin sa_valid_i = 1'b1; sa_sel_vc_i = 2'd1; end
            step();
            if (c == 7) begin
                chk("t7_full_vc1", is_full_o[1], 1'b1);
                chk("t7_on_off_vc1", is_on_off_o[1], 1'b0);
            end
        end
        idle_inputs();

        // route vector table on VC3
        for (int i = 0; i < 6; i++) begin
            tag++;
            data_i = mk(HEADTAIL, 3, i, rtab[i].x, rtab[i].y);
            valid_flit_i = 1'b1;
            step();
            chk("route_table", out_port_o[3], rtab[i].exp_port);
            idle_inputs();
            step();
            va_valid_i[3] = 1'b1; va_new_vc_i[3] = 2'(i % 4);
            step();
            idle_inputs();
            sa_valid_i = 1'b1; sa_sel_vc_i = 2'd3;
            step();
            idle_inputs();
            step();
        end

        // reset in the middle of a packet
        lbl[0] = HEAD; lbl[1] = BODY; lbl[2] = BODY;
        stream(1, 3, 0, 2, 100, 2, 4, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_is_empty", is_empty_o, {VC_NUM{1'b1}});
        chk("midrst_va_request", va_request_o, '0);
        chk("midrst_sa_request", sa_request_o, '0);
        chk("midrst_sa_downstream_vc", sa_downstream_vc_o, '0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        lbl[0] = HEAD; lbl[1] = TAIL;
        stream(1, 2, 0, 2, 0, 3, 8, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
